// File: rtl/parity_run_detector.sv
// Serial bit-stream monitor: y is high once a run of at least RUN_LEN zeros has
// been seen and the running count of sampled ones has the selected parity.
// Also provides a one-cycle rise pulse and a saturating count of rises.
module parity_run_detector #(
    parameter int RUN_LEN     = 2,
    parameter int PARITY_MODE = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             cnt_clr,
    input  logic             x,
    output logic             y,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt
);

    // zrun saturates at RUN_LEN, so it needs enough bits to hold that value.
    localparam int              ZW      = $clog2(RUN_LEN + 1);
    localparam logic [ZW-1:0]   Z_MAX   = ZW'(RUN_LEN);
    localparam logic [ZW-1:0]   Z_THR   = ZW'(RUN_LEN - 1);
    localparam logic [ZW-1:0]   Z_ONE   = ZW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic            PAR_TGT = (PARITY_MODE != 0);

    logic          par, par_next;
    logic [ZW-1:0] zrun, zrun_next;
    logic          found, found_next;
    logic          y_next;
    logic          rise;
    logic [CNT_W-1:0] cnt_next;

    // Next-state of the detector: clear beats sample, sample beats hold.
    always_comb begin
        par_next   = par;
        zrun_next  = zrun;
        found_next = found;
        if (clr) begin
            par_next   = 1'b0;
            zrun_next  = '0;
            found_next = 1'b0;
        end else if (en) begin
            if (x) begin
                par_next  = ~par;
                zrun_next = '0;
            end else begin
                if (zrun < Z_MAX) begin
                    zrun_next = zrun + Z_ONE;
                end
                // zrun + 1 >= RUN_LEN, written without widening zrun
                if (zrun >= Z_THR) begin
                    found_next = 1'b1;
                end
            end
        end
        // y follows the freshly updated state so it has no extra cycle of latency.
        y_next = found_next & (par_next == PAR_TGT);
        // On a hold edge the state is unchanged, so y_next equals y and no rise occurs;
        // on a clear edge y_next is 0, which also suppresses the rise.
        rise   = y_next & ~y;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (rise && (match_cnt != CNT_MAX)) begin
            cnt_next = match_cnt + CNT_ONE;
        end else begin
            cnt_next = match_cnt;
        end
    end

    // Detector state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par         <= 1'b0;
            zrun        <= '0;
            found       <= 1'b0;
            y           <= 1'b0;
            match_pulse <= 1'b0;
            match_cnt   <= '0;
        end else begin
            par         <= par_next;
            zrun        <= zrun_next;
            found       <= found_next;
            y           <= y_next;
            match_pulse <= rise;
            match_cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_parity_run_detector.sv
// Bench for parity_run_detector: three parameterisations share one input stream
// and are compared against a history-based reference model.
module tb_parity_run_detector;

    logic clk;
    logic reset_n;
    logic en, clr, cnt_clr, x;

    logic       y_a, p_a;
    logic [7:0] c_a;
    logic       y_b, p_b;
    logic [7:0] c_b;
    logic       y_c, p_c;
    logic [1:0] c_c;

    int total = 0;
    int bad   = 0;

    // Reference model state: the bits sampled since the last clear.
    bit hist[$];
    int run_len_m[3] = '{2, 3, 2};
    int pm_m[3]      = '{1, 0, 1};
    int max_m[3]     = '{255, 255, 3};
    bit y_m[3];
    bit p_m[3];
    int c_m[3];

    parity_run_detector dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .cnt_clr(cnt_clr), .x(x),
        .y(y_a), .match_pulse(p_a), .match_cnt(c_a)
    );

    parity_run_detector #(.RUN_LEN(3), .PARITY_MODE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .cnt_clr(cnt_clr), .x(x),
        .y(y_b), .match_pulse(p_b), .match_cnt(c_b)
    );

    parity_run_detector #(.CNT_W(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .cnt_clr(cnt_clr), .x(x),
        .y(y_c), .match_pulse(p_c), .match_cnt(c_c)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // y from the rules: some zero run of length >= run_len, ones count of right parity.
    function automatic bit model_y(input int run_len, input int pm);
        int run  = 0;
        int best = 0;
        int ones = 0;
        foreach (hist[i]) begin
            if (hist[i]) begin
                ones++;
                run = 0;
            end else begin
                run++;
                if (run > best) best = run;
            end
        end
        return (best >= run_len) && ((ones % 2) == pm);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) begin
            y_m[i] = 1'b0;
            p_m[i] = 1'b0;
            c_m[i] = 0;
        end
    endtask

    task automatic check_all();
        check("a.y",   32'(y_a), 32'(y_m[0]));
        check("a.pls", 32'(p_a), 32'(p_m[0]));
        check("a.cnt", 32'(c_a), 32'(c_m[0]));
        check("b.y",   32'(y_b), 32'(y_m[1]));
        check("b.pls", 32'(p_b), 32'(p_m[1]));
        check("b.cnt", 32'(c_b), 32'(c_m[1]));
        check("c.y",   32'(y_c), 32'(y_m[2]));
        check("c.pls", 32'(p_c), 32'(p_m[2]));
        check("c.cnt", 32'(c_c), 32'(c_m[2]));
    endtask

    // Drive one edge's inputs, advance the model, then compare just after the edge.
    task automatic step(input bit c, input bit e, input bit xi, input bit cc);
        bit ny, rise;
        clr     = c;
        en      = e;
        x       = xi;
        cnt_clr = cc;
        if (c) hist.delete();
        else if (e) hist.push_back(xi);
        for (int i = 0; i < 3; i++) begin
            ny     = c ? 1'b0 : model_y(run_len_m[i], pm_m[i]);
            rise   = ny && !y_m[i];
            p_m[i] = rise;
            if (cc) c_m[i] = 0;
            else if (rise && c_m[i] < max_m[i]) c_m[i]++;
            y_m[i] = ny;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic feed(input bit xi);
        step(1'b0, 1'b1, xi, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        en = 1'b0; clr = 1'b0; cnt_clr = 1'b0; x = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Build y=1 with five rises, then reset asynchronously mid-cycle.
        feed(1); feed(0); feed(0);
        check("t2.y1", 32'(y_a), 32'd1);
        check("t2.p1", 32'(p_a), 32'd1);
        check("t2.c1", 32'(c_a), 32'd1);
        feed(1);
        check("t2.y0", 32'(y_a), 32'd0);
        feed(1);
        check("t2.y2", 32'(y_a), 32'd1);
        check("t2.c2", 32'(c_a), 32'd2);
        for (int k = 0; k < 6; k++) feed(1);
        check("t1.ypre", 32'(y_a), 32'd1);
        check("t1.cpre", 32'(c_a), 32'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1.y",   32'(y_a), 32'd0);
        check("t1.pls", 32'(p_a), 32'd0);
        check("t1.cnt", 32'(c_a), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Even parity after two zeros, then a one makes it odd.
        step(1, 1, 0, 1);
        feed(0); feed(0);
        check("t3.y0", 32'(y_a), 32'd0);
        feed(1);
        check("t3.y1", 32'(y_a), 32'd1);
        check("t3.c1", 32'(c_a), 32'd1);

        // Broken run on the RUN_LEN=3 even-parity instance, then a hold window.
        step(1, 0, 0, 1);
        feed(0); feed(0); feed(1); feed(1); feed(0); feed(0);
        check("t4.y0", 32'(y_b), 32'd0);
        feed(0);
        check("t4.y1", 32'(y_b), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, k[0], 0);
            check("t4.hold", 32'(p_b), 32'd0);
        end

        // Clear drops found; parity restarts even.
        step(1, 0, 0, 0);
        feed(1); feed(0);
        step(1, 1, 0, 0);
        check("t5.y", 32'(y_a), 32'd0);
        feed(0); feed(0);
        check("t5.y2", 32'(y_a), 32'd0);

        // Saturation on the 2-bit counter and cnt_clr beating an increment.
        step(1, 0, 0, 1);
        feed(1); feed(0); feed(0);
        check("t6.c1", 32'(c_c), 32'd1);
        feed(1); feed(1);
        check("t6.c2", 32'(c_c), 32'd2);
        feed(1); feed(1);
        check("t6.c3", 32'(c_c), 32'd3);
        feed(1); feed(1);
        check("t6.c3s", 32'(c_c), 32'd3);
        feed(1);
        step(0, 1, 1, 1);
        check("t6.cclr", 32'(c_c), 32'd0);
        check("t6.pls",  32'(p_c), 32'd1);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
